// File: rtl/matrix_msg_pkg.sv
// Shared widths and message layout for the matrix-init message FIFO.
package matrix_msg_pkg;

    localparam int DEF_TYPE_BITS    = 1;
    localparam int DEF_COORD_BITS   = 8;
    localparam int DEF_ELEMENT_BITS = 32;
    localparam int DEF_MATRIX_DIM   = 4;
    localparam int DEF_FIFO_DEPTH   = 16;

    typedef struct packed {
        logic [DEF_TYPE_BITS-1:0]    msg_type;
        logic [DEF_COORD_BITS-1:0]   x;
        logic [DEF_COORD_BITS-1:0]   y;
        logic [DEF_ELEMENT_BITS-1:0] element;
    } matrix_msg_t;

    localparam int MATRIX_MSG_BITS = $bits(matrix_msg_t);

endpackage

// File: rtl/matrix_msg_ram.sv
// Message storage: synchronous write, asynchronous read, no reset on contents.
module matrix_msg_ram
    import matrix_msg_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = MATRIX_MSG_BITS,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/matrix_message_fifo.sv
// First-word-fall-through FIFO feeding the core's matrix-init port, with head bounds check.
// Define MATRIX_FIFO_DROP_COUNT_EN to add the saturating dropped_count output.
module matrix_message_fifo
    import matrix_msg_pkg::*;
#(
    parameter int MATRIX_TYPE_BITS    = DEF_TYPE_BITS,
    parameter int MATRIX_COORD_BITS   = DEF_COORD_BITS,
    parameter int MATRIX_ELEMENT_BITS = DEF_ELEMENT_BITS,
    parameter int MATRIX_DIM          = DEF_MATRIX_DIM,
    parameter int FIFO_DEPTH          = DEF_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [MATRIX_TYPE_BITS-1:0]      msg_type_in,
    input  logic [MATRIX_COORD_BITS-1:0]     msg_x_coord_in,
    input  logic [MATRIX_COORD_BITS-1:0]     msg_y_coord_in,
    input  logic [MATRIX_ELEMENT_BITS-1:0]   msg_element_in,
    input  logic                             msg_in_valid,
    output logic                             msg_in_ready,
    output logic [MATRIX_TYPE_BITS-1:0]      matrix_type_out,
    output logic [MATRIX_COORD_BITS-1:0]     matrix_x_coord_out,
    output logic [MATRIX_COORD_BITS-1:0]     matrix_y_coord_out,
    output logic [MATRIX_ELEMENT_BITS-1:0]   matrix_element_out,
    output logic                             message_out_available,
    output logic                             message_out_valid,
    input  logic                             message_out_read,
`ifdef MATRIX_FIFO_DROP_COUNT_EN
    output logic [15:0]                      dropped_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MSG_W = MATRIX_TYPE_BITS + 2 * MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS;

    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0] count;
    logic [MSG_W-1:0] wr_msg, ram_next, head;
    logic             push, pop;

    // Write side is valid/ready: a message transfers on any edge where both are high.
    // Read side is a pop pulse, honoured only while a message is available.
    assign push    = msg_in_valid && msg_in_ready;
    assign pop     = message_out_read && message_out_available;
    assign rd_next = rd_ptr + PTR_W'(1);
    assign wr_msg  = {msg_type_in, msg_x_coord_in, msg_y_coord_in, msg_element_in};

    matrix_msg_ram #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MSG_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_msg),
        .raddr (rd_next),
        .rdata (ram_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_next;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // The RAM read is taken before this edge's write lands, so a message pushed
    // into an empty FIFO (or while its only entry leaves) is bypassed into the head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
        end else if (pop && count > CNT_W'(1)) begin
            head <= ram_next;
        end else if (push && (count == '0 || (pop && count == CNT_W'(1)))) begin
            head <= wr_msg;
        end
    end

    assign {matrix_type_out, matrix_x_coord_out, matrix_y_coord_out, matrix_element_out} = head;

    assign fifo_count            = count;
    assign msg_in_ready          = (count != CNT_W'(FIFO_DEPTH));
    assign message_out_available = (count != '0);
    assign message_out_valid     = message_out_available
                                   && (matrix_x_coord_out < MATRIX_COORD_BITS'(MATRIX_DIM))
                                   && (matrix_y_coord_out < MATRIX_COORD_BITS'(MATRIX_DIM));

`ifdef MATRIX_FIFO_DROP_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dropped_count <= '0;
        end else if (msg_in_valid && !msg_in_ready && dropped_count != 16'hFFFF) begin
            dropped_count <= dropped_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_message_fifo.sv
// Scoreboard bench for matrix_message_fifo: directed pushes/pops, monitor checks every pop.
module tb_matrix_message_fifo;
    import matrix_msg_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [0:0]  msg_type_in = '0;
    logic [7:0]  msg_x_coord_in = '0;
    logic [7:0]  msg_y_coord_in = '0;
    logic [31:0] msg_element_in = '0;
    logic        msg_in_valid = 1'b0;
    logic        msg_in_ready;
    logic [0:0]  matrix_type_out;
    logic [7:0]  matrix_x_coord_out;
    logic [7:0]  matrix_y_coord_out;
    logic [31:0] matrix_element_out;
    logic        message_out_available;
    logic        message_out_valid;
    logic        message_out_read = 1'b0;
    logic [4:0]  fifo_count;
`ifdef MATRIX_FIFO_DROP_COUNT_EN
    logic [15:0] dropped_count;
`endif

    logic [MATRIX_MSG_BITS-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    matrix_message_fifo dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .msg_type_in           (msg_type_in),
        .msg_x_coord_in        (msg_x_coord_in),
        .msg_y_coord_in        (msg_y_coord_in),
        .msg_element_in        (msg_element_in),
        .msg_in_valid          (msg_in_valid),
        .msg_in_ready          (msg_in_ready),
        .matrix_type_out       (matrix_type_out),
        .matrix_x_coord_out    (matrix_x_coord_out),
        .matrix_y_coord_out    (matrix_y_coord_out),
        .matrix_element_out    (matrix_element_out),
        .message_out_available (message_out_available),
        .message_out_valid     (message_out_valid),
        .message_out_read      (message_out_read),
`ifdef MATRIX_FIFO_DROP_COUNT_EN
        .dropped_count         (dropped_count),
`endif
        .fifo_count            (fifo_count)
    );

    // clock
    always #5 clk = ~clk;

    function automatic matrix_msg_t mk(input int t, input int x, input int y, input int e);
        matrix_msg_t m;
        m.msg_type = t[0:0];
        m.x        = x[7:0];
        m.y        = y[7:0];
        m.element  = e;
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input logic wr, input matrix_msg_t m, input logic rd, input logic accept);
        msg_in_valid     = wr;
        {msg_type_in, msg_x_coord_in, msg_y_coord_in, msg_element_in} = m;
        message_out_read = rd;
        if (wr && accept) exp_q.push_back(m);
        @(posedge clk);
        #1;
        msg_in_valid     = 1'b0;
        message_out_read = 1'b0;
    endtask

    task automatic push(input matrix_msg_t m);
        step(1'b1, m, 1'b0, 1'b1);
    endtask

    task automatic pop();
        step(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0);
    endtask

    // scoreboard monitor: every accepted pop must match the oldest expected message
    always @(negedge clk) begin
        if (reset_n && message_out_read && message_out_available) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got element 0x%0h expected no message", matrix_element_out);
            end else begin
                matrix_msg_t e;
                e = exp_q.pop_front();
                chk("pop_head", 64'({matrix_type_out, matrix_x_coord_out, matrix_y_coord_out, matrix_element_out}), 64'(e));
                chk("pop_valid", 64'(message_out_valid), 64'((e.x < 8'd4) && (e.y < 8'd4)));
            end
        end
    end

    initial begin
        // reset state
        #2;
        chk("rst_ready", 64'(msg_in_ready), 64'd1);
        chk("rst_avail", 64'(message_out_available), 64'd0);
        chk("rst_valid", 64'(message_out_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_head", 64'({matrix_type_out, matrix_x_coord_out, matrix_y_coord_out, matrix_element_out}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // first push: latency 1
        push(mk(0, 1, 2, 32'h11));
        chk("first_avail", 64'(message_out_available), 64'd1);
        chk("first_valid", 64'(message_out_valid), 64'd1);
        chk("first_count", 64'(fifo_count), 64'd1);
        chk("first_head", 64'({matrix_type_out, matrix_x_coord_out, matrix_y_coord_out, matrix_element_out}),
            64'(mk(0, 1, 2, 32'h11)));
        pop();
        chk("first_drain_avail", 64'(message_out_available), 64'd0);

        // fill to full
        for (int i = 0; i < 16; i++) begin
            push(mk(i % 2, i % 4, (i / 4) % 4, i));
            chk("fill_count", 64'(fifo_count), 64'(i + 1));
        end
        chk("full_ready", 64'(msg_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, mk(1, 3, 3, 99), 1'b0, 1'b0);
        chk("full_hold_count", 64'(fifo_count), 64'd16);
`ifdef MATRIX_FIFO_DROP_COUNT_EN
        chk("dropped_count", 64'(dropped_count), 64'd3);
`endif
        // pop while full with the held push: push not taken, ready returns
        step(1'b1, mk(1, 3, 3, 99), 1'b1, 1'b0);
        chk("pop_full_ready", 64'(msg_in_ready), 64'd1);
        chk("pop_full_count", 64'(fifo_count), 64'd15);
        for (int i = 0; i < 15; i++) begin
            chk("drain_avail", 64'(message_out_available), 64'd1);
            pop();
        end
        chk("drained_avail", 64'(message_out_available), 64'd0);
        chk("drained_count", 64'(fifo_count), 64'd0);

        // out-of-range head is available but not valid
        push(mk(0, 4, 0, 32'h44));
        push(mk(1, 3, 3, 32'h55));
        chk("oor_avail", 64'(message_out_available), 64'd1);
        chk("oor_valid", 64'(message_out_valid), 64'd0);
        pop();
        chk("after_oor_valid", 64'(message_out_valid), 64'd1);
        chk("after_oor_elem", 64'(matrix_element_out), 64'h55);
        pop();

        // simultaneous push and pop at count 1, then pop while empty
        push(mk(0, 0, 1, 5));
        step(1'b1, mk(0, 2, 3, 7), 1'b1, 1'b1);
        chk("pushpop_count", 64'(fifo_count), 64'd1);
        chk("pushpop_head", 64'(matrix_element_out), 64'd7);
        pop();
        pop();
        chk("empty_pop_count", 64'(fifo_count), 64'd0);
        chk("empty_pop_ready", 64'(msg_in_ready), 64'd1);
        push(mk(1, 1, 1, 8));
        chk("after_empty_pop_head", 64'(matrix_element_out), 64'd8);
        chk("after_empty_pop_count", 64'(fifo_count), 64'd1);
        pop();

        // asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) push(mk(0, i, i, 32'h100 + i));
        chk("pre_reset_count", 64'(fifo_count), 64'd5);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_count", 64'(fifo_count), 64'd0);
        chk("arst_avail", 64'(message_out_available), 64'd0);
        chk("arst_ready", 64'(msg_in_ready), 64'd1);
        chk("arst_head", 64'({matrix_type_out, matrix_x_coord_out, matrix_y_coord_out, matrix_element_out}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        push(mk(1, 2, 3, 32'hABCD));
        chk("post_reset_head", 64'({matrix_type_out, matrix_x_coord_out, matrix_y_coord_out, matrix_element_out}),
            64'(mk(1, 2, 3, 32'hABCD)));
        chk("post_reset_count", 64'(fifo_count), 64'd1);
        pop();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_message_fifo.md
# matrix_message_fifo

Buffers matrix-initialisation messages (type, x coordinate, y coordinate, element) arriving from the loader/network side and presents them one at a time to the single-core system's matrix-init input port. The block sits directly upstream of the core: it drives the core's `matrix_*_in`, `message_in_valid` and `message_in_available` inputs, and it consumes the core's one-cycle `message_in_read` pulse as a pop. It is a first-word-fall-through FIFO with bounds checking on the head entry.

## Interface
- `MATRIX_TYPE_BITS`, 1: message type width.
- `MATRIX_COORD_BITS`, 8: x/y coordinate width.
- `MATRIX_ELEMENT_BITS`, 32: element width.
- `MATRIX_DIM`, 4: matrix is `MATRIX_DIM`×`MATRIX_DIM`; coordinates must be < `MATRIX_DIM`.
- `FIFO_DEPTH`, 16: total message capacity; power of two, ≥2.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `msg_type_in` input `MATRIX_TYPE_BITS`: write-side type.
- `msg_x_coord_in` input `MATRIX_COORD_BITS`: write-side x.
- `msg_y_coord_in` input `MATRIX_COORD_BITS`: write-side y.
- `msg_element_in` input `MATRIX_ELEMENT_BITS`: write-side element.
- `msg_in_valid` input 1: write request.
- `msg_in_ready` output 1: FIFO can accept.
- `matrix_type_out` output `MATRIX_TYPE_BITS`: head type.
- `matrix_x_coord_out` output `MATRIX_COORD_BITS`: head x.
- `matrix_y_coord_out` output `MATRIX_COORD_BITS`: head y.
- `matrix_element_out` output `MATRIX_ELEMENT_BITS`: head element.
- `message_out_available` output 1: head holds a message (FIFO non-empty).
- `message_out_valid` output 1: head holds a message with both coordinates < `MATRIX_DIM`.
- `message_out_read` input 1: pop pulse from the core.
- `fifo_count` output `$clog2(FIFO_DEPTH)+1`: messages held.

## Operation
- Push occurs when `msg_in_valid && msg_in_ready`. `msg_in_ready = (fifo_count != FIFO_DEPTH)` is combinational from the count register.
- The head is a registered copy of the oldest entry. The head fields hold their last value when empty; the default is zero after reset.
- A pop occurs when `message_out_read && message_out_available`. `message_out_read` while empty is ignored: there is no underflow, and count stays 0.
- Simultaneous push and pop: count is unchanged and order is preserved. If count==1, the pushed message becomes the new head.
- `message_out_valid = message_out_available && x < MATRIX_DIM && y < MATRIX_DIM`. An out-of-range head is still available and poppable, so the core discards it by reading.
- Write and read pointers wrap modulo `FIFO_DEPTH`.
- Reset, including mid-operation: all buffered messages are dropped. Pointers, count, head fields and flags go to 0, `msg_in_ready` goes to 1, and no message survives reset.

## Timing
- Reset values: `msg_in_ready`=1, `message_out_available`=0, `message_out_valid`=0, `fifo_count`=0, head fields 0.
- Push into an empty FIFO at edge N: head fields, `message_out_available` and `fifo_count`=1 are visible after edge N (latency 1).
- Pop at edge N with a remaining entry: the next head is visible after edge N. `message_out_available` stays high, with no bubble.
- Pop of the last entry at edge N: `message_out_available` is 0 after edge N.
- Full: a push attempted while `msg_in_ready`=0 is not accepted. The writer must hold the data; nothing is written.
- Pop while full at edge N: `msg_in_ready` is 1 after edge N. A same-cycle push while full is never accepted, because ready was low in that cycle.

## Configuration
- `MATRIX_FIFO_DROP_COUNT_EN`: when defined, adds output `dropped_count` (16 bits), incremented on every cycle with `msg_in_valid && !msg_in_ready`. It saturates at 0xFFFF and is reset to 0.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `matrix_msg_pkg`: width defaults, the message struct typedef (type, x, y, element), and the packed message width constant.
- One sub-module, `matrix_msg_ram`: `FIFO_DEPTH`×message-width storage with synchronous write and asynchronous read. Pointer, count and head logic lives in the top level.

## Test plan
- Reset, then push (type 0, x 1, y 2, element 0x11) → after 1 cycle, available=1, valid=1, head=(0,1,2,0x11), count=1.
- Push 16 messages with element 0..15 without pops → ready=0 at count 16. A 17th push with element 99 is held off. Pop all 16 → elements 0..15 appear in order, and available=0 afterwards.
- Push a message with x=4 (`MATRIX_DIM`=4) → available=1, valid=0. Pop it → the next message is presented normally.
- Count=1 with a simultaneous push (element 7) and pop → count stays 1 and the head becomes element 7. Pop with count 0 → count stays 0 and there is no pointer change.
- Assert `reset_n`=0 with count=5 → outputs are at reset values immediately (asynchronous). After release, the first push is presented correctly.
- With `MATRIX_FIFO_DROP_COUNT_EN`: hold `msg_in_valid` for 3 cycles while full → `dropped_count`=3.
